// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the CPU MEM stage and a DMA port, with 1-cycle read return.
// Optional anti-starvation guard for the DMA port is compiled in by DMEM_ARB_STARVE_GUARD_EN.
module dmem_arbiter #(
  parameter int width        = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [width-1:0] cpu_addr,
  input  logic [width-1:0] cpu_wdata,
  input  logic             dma_req,
  input  logic             dma_we,
  input  logic [width-1:0] dma_addr,
  input  logic [width-1:0] dma_wdata,
  output logic             cpu_gnt,
  output logic             dma_gnt,
  output logic             cpu_stall,
  output logic [width-1:0] cpu_rdata,
  output logic [width-1:0] dma_rdata,
  output logic             cpu_rvalid,
  output logic             dma_rvalid,
  output logic             dma_ack,
  output logic             mem_we,
  output logic [width-1:0] mem_addr,
  output logic [width-1:0] mem_wdata,
  input  logic [width-1:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_CPU, S_DMA} owner_e;

  owner_e             state_q, state_d;
  logic               rd_q, rd_d;
  logic [width-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [width-1:0]   dma_rdata_q, dma_rdata_d;
  logic               force_dma;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_q, starve_d;

  assign force_dma = cpu_req & dma_req & (starve_q == LIMIT);

  // Counts contended cycles the CPU has won in a row; any DMA grant or idle DMA clears it.
  always_comb begin
    starve_d = starve_q;
    if (!dma_req || dma_gnt)
      starve_d = '0;
    else if (cpu_gnt && (starve_q != LIMIT))
      starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) starve_q <= '0;
    else        starve_q <= starve_d;
  end
`else
  // Never true for a legal limit: the CPU keeps strict priority.
  assign force_dma = (STARVE_LIMIT < 1);
`endif

  assign cpu_gnt   = rst_n & cpu_req & ~force_dma;
  assign dma_gnt   = rst_n & dma_req & (~cpu_req | force_dma);
  assign cpu_stall = cpu_req & ~cpu_gnt;

  assign mem_addr  = dma_gnt ? dma_addr  : cpu_addr;
  assign mem_wdata = dma_gnt ? dma_wdata : cpu_wdata;
  assign mem_we    = (cpu_gnt & cpu_we) | (dma_gnt & dma_we);

  // NOTE: every signal gets a default before the branches, so no latch is inferred.
  always_comb begin
    state_d     = S_IDLE;
    rd_d        = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    if (cpu_gnt) begin
      state_d = S_CPU;
      rd_d    = ~cpu_we;
      if (!cpu_we) cpu_rdata_d = mem_rdata;
    end else if (dma_gnt) begin
      state_d = S_DMA;
      rd_d    = ~dma_we;
      if (!dma_we) dma_rdata_d = mem_rdata;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rd_q        <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  // Return pulses decode from last cycle's owner and whether that access was a read.
  assign cpu_rvalid = (state_q == S_CPU) & rd_q;
  assign dma_rvalid = (state_q == S_DMA) & rd_q;
  assign dma_ack    = (state_q == S_DMA);
  assign cpu_rdata  = cpu_rdata_q;
  assign dma_rdata  = dma_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed spec scenarios plus randomized traffic
// checked against a cycle-level behavioural model with its own reference memory.
module tb_dmem_arbiter;
  localparam int W     = 32;
  localparam int LIMIT = 3;
`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         cpu_req, cpu_we, dma_req, dma_we;
  logic [W-1:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic         cpu_gnt, dma_gnt, cpu_stall;
  logic [W-1:0] cpu_rdata, dma_rdata;
  logic         cpu_rvalid, dma_rvalid, dma_ack;
  logic         mem_we;
  logic [W-1:0] mem_addr, mem_wdata, mem_rdata;

  dmem_arbiter #(.width(W), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .cpu_gnt(cpu_gnt), .dma_gnt(dma_gnt), .cpu_stall(cpu_stall),
    .cpu_rdata(cpu_rdata), .dma_rdata(dma_rdata),
    .cpu_rvalid(cpu_rvalid), .dma_rvalid(dma_rvalid), .dma_ack(dma_ack),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Harness data memory: 16 words, combinational read, written on the rising edge.
  logic [W-1:0] hmem [16];
  assign mem_rdata = hmem[mem_addr[5:2]];
  always @(posedge clk) if (mem_we) hmem[mem_addr[5:2]] <= mem_wdata;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state.
  logic [W-1:0] ref_mem [16];
  int           streak = 0;
  bit           p_cpu_rv = 0, p_dma_rv = 0, p_ack = 0;
  logic [W-1:0] m_cpu_rdata = '0, m_dma_rdata = '0;
  bit           e_cpu_gnt, e_dma_gnt, e_stall, e_we;
  logic [W-1:0] e_addr, e_wdata;

  task automatic model_eval();
    bit both, force_d;
    both      = cpu_req && dma_req;
    force_d   = GUARD && both && (streak == LIMIT);
    e_cpu_gnt = rst_n && cpu_req && !force_d;
    e_dma_gnt = rst_n && dma_req && (!cpu_req || force_d);
    e_stall   = cpu_req && !e_cpu_gnt;
    e_we      = (e_cpu_gnt && cpu_we) || (e_dma_gnt && dma_we);
    e_addr    = e_dma_gnt ? dma_addr  : cpu_addr;
    e_wdata   = e_dma_gnt ? dma_wdata : cpu_wdata;
  endtask

  task automatic model_commit();
    if (!rst_n) begin
      p_cpu_rv = 0; p_dma_rv = 0; p_ack = 0;
      m_cpu_rdata = '0; m_dma_rdata = '0; streak = 0;
    end else begin
      p_cpu_rv = e_cpu_gnt && !cpu_we;
      p_dma_rv = e_dma_gnt && !dma_we;
      p_ack    = e_dma_gnt;
      if (p_cpu_rv) m_cpu_rdata = ref_mem[cpu_addr[5:2]];
      if (p_dma_rv) m_dma_rdata = ref_mem[dma_addr[5:2]];
      if (e_cpu_gnt && cpu_we) ref_mem[cpu_addr[5:2]] = cpu_wdata;
      if (e_dma_gnt && dma_we) ref_mem[dma_addr[5:2]] = dma_wdata;
      if (!dma_req || e_dma_gnt) streak = 0;
      else if (cpu_req && e_cpu_gnt && streak < LIMIT) streak++;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; dma_req = 0; dma_we = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; cpu_req = 1; dma_req = 1; cpu_we = 1; dma_we = 1;
    cpu_addr = 32'h4; dma_addr = 32'h8; cpu_wdata = 32'h1; dma_wdata = 32'h2;
    for (int i = 0; i < 2; i++) begin
      sample();
      n_cmp++;
      if ({cpu_gnt, dma_gnt, mem_we, cpu_stall} !== 4'b0001) begin
        n_bad++;
        $display("FAIL reset_gnt cyc%0d: gnt/gnt/we/stall=%b want 0001", i,
                 {cpu_gnt, dma_gnt, mem_we, cpu_stall});
      end
      n_cmp++;
      if ({cpu_rvalid, dma_rvalid, dma_ack, cpu_rdata, dma_rdata} !== '0) begin
        n_bad++;
        $display("FAIL reset_regs cyc%0d: rv=%b%b ack=%b crd=%h drd=%h want all 0", i,
                 cpu_rvalid, dma_rvalid, dma_ack, cpu_rdata, dma_rdata);
      end
      advance();
    end
    rst_n = 1; idle_inputs();
    sample();
    n_cmp++;
    if ({cpu_rvalid, dma_rvalid, dma_ack, cpu_rdata, dma_rdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_release: rv=%b%b ack=%b crd=%h drd=%h want all 0",
               cpu_rvalid, dma_rvalid, dma_ack, cpu_rdata, dma_rdata);
    end
    advance();
  endtask

  // Back-to-back DMA writes fill the memory, then the 0x20 write is checked in detail.
  task automatic test_dma_write();
    for (int i = 0; i < 16; i++) begin
      dma_req = 1; dma_we = 1; dma_addr = W'(i * 4);
      dma_wdata = (i == 4) ? 32'hDEADBEEF : $urandom;
      sample();
      n_cmp++;
      if (dma_ack !== (i > 0)) begin
        n_bad++;
        $display("FAIL dma_fill_ack i=%0d: ack=%b want %b", i, dma_ack, i > 0);
      end
      advance();
    end
    dma_addr = 32'h20; dma_wdata = 32'h12345678;
    sample();
    n_cmp++;
    if ({dma_gnt, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h20, 32'h12345678}) begin
      n_bad++;
      $display("FAIL dma_write: gnt=%b we=%b addr=%h wdata=%h want 1 1 00000020 12345678",
               dma_gnt, mem_we, mem_addr, mem_wdata);
    end
    advance();
    idle_inputs();
    sample();
    n_cmp++;
    if ({dma_ack, dma_rvalid, mem_we} !== 3'b100) begin
      n_bad++;
      $display("FAIL dma_write_ack: ack=%b rvalid=%b mem_we=%b want 1 0 0", dma_ack, dma_rvalid, mem_we);
    end
    advance();
  endtask

  task automatic test_cpu_read();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10; cpu_wdata = $urandom;
    sample();
    n_cmp++;
    if ({cpu_gnt, cpu_stall, mem_we, mem_addr} !== {3'b100, 32'h10}) begin
      n_bad++;
      $display("FAIL cpu_read_gnt: gnt=%b stall=%b we=%b addr=%h want 1 0 0 00000010",
               cpu_gnt, cpu_stall, mem_we, mem_addr);
    end
    advance();
    idle_inputs();
    sample();
    n_cmp++;
    if ({cpu_rvalid, cpu_rdata} !== {1'b1, 32'hDEADBEEF}) begin
      n_bad++;
      $display("FAIL cpu_read_ret: rvalid=%b rdata=%h want 1 deadbeef", cpu_rvalid, cpu_rdata);
    end
    advance();
    sample();
    n_cmp++;
    if ({cpu_rvalid, cpu_rdata} !== {1'b0, 32'hDEADBEEF}) begin
      n_bad++;
      $display("FAIL cpu_read_hold: rvalid=%b rdata=%h want 0 deadbeef", cpu_rvalid, cpu_rdata);
    end
    advance();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin cpu_req = 1; cpu_we = 0; cpu_addr = W'(32'h20 + i * 4); end
      else idle_inputs();
      sample();
      if (i > 0) begin
        n_cmp++;
        if ({cpu_rvalid, cpu_rdata} !== {1'b1, m_cpu_rdata}) begin
          n_bad++;
          $display("FAIL b2b_cpu i=%0d: rvalid=%b rdata=%h want 1 %h", i, cpu_rvalid, cpu_rdata, m_cpu_rdata);
        end
      end
      if (i == 1) begin
        n_cmp++;
        if (cpu_rdata !== 32'h12345678) begin
          n_bad++;
          $display("FAIL b2b_first: rdata=%h want 12345678", cpu_rdata);
        end
      end
      advance();
    end
    for (int i = 0; i < 3; i++) begin
      if (i < 2) begin dma_req = 1; dma_we = 0; dma_addr = W'(32'h10 + i * 4); end
      else idle_inputs();
      sample();
      if (i > 0) begin
        n_cmp++;
        if ({dma_rvalid, dma_ack, dma_rdata} !== {2'b11, m_dma_rdata}) begin
          n_bad++;
          $display("FAIL b2b_dma i=%0d: rvalid=%b ack=%b rdata=%h want 1 1 %h",
                   i, dma_rvalid, dma_ack, dma_rdata, m_dma_rdata);
        end
      end
      advance();
    end
  endtask

  task automatic test_contention();
    bit exp_dma, prev_dma;
    idle_inputs();
    sample(); advance();
    prev_dma = 0;
    for (int i = 0; i < 21; i++) begin
      if (i < 20) begin
        cpu_req = 1; cpu_we = 0; cpu_addr = W'($urandom_range(0, 63));
        dma_req = 1; dma_we = 0; dma_addr = W'($urandom_range(0, 63));
      end else idle_inputs();
      exp_dma = GUARD && (i % 4 == 3) && (i < 20);
      sample();
      if (i < 20) begin
        n_cmp++;
        if ({cpu_gnt, dma_gnt, cpu_stall} !== {!exp_dma, exp_dma, exp_dma}) begin
          n_bad++;
          $display("FAIL contention i=%0d: cpu_gnt=%b dma_gnt=%b stall=%b want %b %b %b",
                   i, cpu_gnt, dma_gnt, cpu_stall, !exp_dma, exp_dma, exp_dma);
        end
      end
      n_cmp++;
      if (dma_ack !== prev_dma) begin
        n_bad++;
        $display("FAIL contention_ack i=%0d: ack=%b want %b", i, dma_ack, prev_dma);
      end
      prev_dma = exp_dma;
      advance();
    end
  endtask

  task automatic test_reset_mid_read();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    sample();
    n_cmp++;
    if (cpu_gnt !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_gnt: cpu_gnt=%b want 1", cpu_gnt);
    end
    #1 rst_n = 0;
    advance();
    rst_n = 1; idle_inputs();
    sample();
    n_cmp++;
    if ({cpu_rvalid, cpu_rdata} !== {1'b0, 32'h0}) begin
      n_bad++;
      $display("FAIL midrst_cancel: rvalid=%b rdata=%h want 0 00000000", cpu_rvalid, cpu_rdata);
    end
    advance();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst_n     = ($urandom_range(0, 49) != 0) || (i > 390);
      cpu_req   = ($urandom_range(0, 9) < 7); cpu_we = $urandom_range(0, 1);
      cpu_addr  = W'($urandom_range(0, 63));  cpu_wdata = $urandom;
      dma_req   = ($urandom_range(0, 9) < 6); dma_we = $urandom_range(0, 1);
      dma_addr  = W'($urandom_range(0, 63));  dma_wdata = $urandom;
      sample();
      n_cmp++;
      if ({cpu_gnt, dma_gnt, cpu_stall, mem_we} !== {e_cpu_gnt, e_dma_gnt, e_stall, e_we}) begin
        n_bad++;
        $display("FAIL rnd_ctrl i=%0d: cg/dg/st/we=%b%b%b%b want %b%b%b%b", i,
                 cpu_gnt, dma_gnt, cpu_stall, mem_we, e_cpu_gnt, e_dma_gnt, e_stall, e_we);
      end
      n_cmp++;
      if ({mem_addr, mem_wdata} !== {e_addr, e_wdata}) begin
        n_bad++;
        $display("FAIL rnd_mux i=%0d: addr=%h wdata=%h want %h %h", i, mem_addr, mem_wdata, e_addr, e_wdata);
      end
      n_cmp++;
      if ({cpu_rvalid, dma_rvalid, dma_ack} !== {p_cpu_rv, p_dma_rv, p_ack}) begin
        n_bad++;
        $display("FAIL rnd_pulse i=%0d: crv/drv/ack=%b%b%b want %b%b%b", i,
                 cpu_rvalid, dma_rvalid, dma_ack, p_cpu_rv, p_dma_rv, p_ack);
      end
      n_cmp++;
      if ({cpu_rdata, dma_rdata} !== {m_cpu_rdata, m_dma_rdata}) begin
        n_bad++;
        $display("FAIL rnd_rdata i=%0d: crd=%h drd=%h want %h %h", i,
                 cpu_rdata, dma_rdata, m_cpu_rdata, m_dma_rdata);
      end
      advance();
    end
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    cpu_addr = '0; cpu_wdata = '0; dma_addr = '0; dma_wdata = '0;
    test_reset();
    test_dma_write();
    test_cpu_read();
    test_back_to_back();
    test_contention();
    test_reset_mid_read();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
